// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI4 read-channel arbiter: instruction fetch (ic) and data load (dc)
// share one AR/R pair, one transaction outstanding, DC priority with IC anti-starvation.
module axi_rd_arbiter #(
  parameter int         STARVE_LIMIT = 4,
  parameter logic [3:0] IC_ID        = 4'd0,
  parameter logic [3:0] DC_ID        = 4'd1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        ic_arvalid,
  output logic        ic_arready,
  input  logic [31:0] ic_araddr,
  input  logic [7:0]  ic_arlen,
  output logic        ic_rvalid,
  output logic [31:0] ic_rdata,
  output logic        ic_rlast,
  output logic [1:0]  ic_rresp,
  input  logic        dc_arvalid,
  output logic        dc_arready,
  input  logic [31:0] dc_araddr,
  input  logic [7:0]  dc_arlen,
  output logic        dc_rvalid,
  output logic [31:0] dc_rdata,
  output logic        dc_rlast,
  output logic [1:0]  dc_rresp,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic [3:0]  m_arid,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] m_rdata,
  input  logic        m_rlast,
  input  logic [1:0]  m_rresp
);

  localparam int              SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t        state;
  logic          own;
  logic [SW-1:0] starve;

  // DC wins ties until IC has been passed over STARVE_LIMIT times in a row.
  logic dc_wins;
  assign dc_wins = dc_arvalid && (!ic_arvalid || (starve != STARVE_MAX));

  // Arbitration FSM; m_arvalid and m_rready are registered alongside the state.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= IDLE;
      own       <= 1'b0;
      starve    <= '0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dc_wins) begin
            own       <= 1'b1;
            state     <= ADDR;
            m_arvalid <= 1'b1;
            if (ic_arvalid) begin
              starve <= starve + SW'(1);
            end
          end else if (ic_arvalid) begin
            own       <= 1'b0;
            starve    <= '0;
            state     <= ADDR;
            m_arvalid <= 1'b1;
          end
        end
        ADDR: begin
          if (m_arready) begin
            state     <= DATA;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
          end
        end
        DATA: begin
          if (m_rvalid && m_rlast) begin
            state    <= IDLE;
            m_rready <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          m_arvalid <= 1'b0;
          m_rready  <= 1'b0;
        end
      endcase
    end
  end

  assign m_araddr  = own ? dc_araddr : ic_araddr;
  assign m_arlen   = own ? dc_arlen  : ic_arlen;
  assign m_arid    = own ? DC_ID     : IC_ID;
  assign m_arsize  = 3'b010;
  assign m_arburst = 2'b01;

  assign ic_arready = m_arvalid && !own && m_arready;
  assign dc_arready = m_arvalid &&  own && m_arready;

  // Requesters cannot stall, so beats are steered by owner only.
  assign ic_rvalid = m_rready && !own && m_rvalid;
  assign dc_rvalid = m_rready &&  own && m_rvalid;

  assign ic_rdata = m_rdata;
  assign ic_rlast = m_rlast;
  assign ic_rresp = m_rresp;
  assign dc_rdata = m_rdata;
  assign dc_rlast = m_rlast;
  assign dc_rresp = m_rresp;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: AXI slave model, requester models and a
// scoreboard of expected AR issues and R beats.
module tb_axi_rd_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        ic_arvalid = 1'b0, dc_arvalid = 1'b0;
  logic [31:0] ic_araddr = 32'h0, dc_araddr = 32'h0;
  logic [7:0]  ic_arlen = 8'h0, dc_arlen = 8'h0;
  logic        ic_arready, dc_arready, ic_rvalid, dc_rvalid, ic_rlast, dc_rlast;
  logic [31:0] ic_rdata, dc_rdata;
  logic [1:0]  ic_rresp, dc_rresp;
  logic        m_arvalid, m_rready;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic [3:0]  m_arid;
  logic        m_arready = 1'b0, m_rvalid = 1'b0, m_rlast = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  logic [1:0]  m_rresp = 2'b00;

  always #5 aclk = ~aclk;

  axi_rd_arbiter #(.STARVE_LIMIT(4), .IC_ID(4'd0), .DC_ID(4'd1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .ic_arvalid(ic_arvalid), .ic_arready(ic_arready), .ic_araddr(ic_araddr), .ic_arlen(ic_arlen),
    .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata), .ic_rlast(ic_rlast), .ic_rresp(ic_rresp),
    .dc_arvalid(dc_arvalid), .dc_arready(dc_arready), .dc_araddr(dc_araddr), .dc_arlen(dc_arlen),
    .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata), .dc_rlast(dc_rlast), .dc_rresp(dc_rresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arid(m_arid),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rresp(m_rresp)
  );

  typedef struct {logic own; logic [31:0] addr; logic [7:0] len;} ar_t;
  typedef struct {logic own; logic [31:0] data; logic [1:0] resp; logic last;} beat_t;

  ar_t   ar_q[$];
  beat_t beat_q[$];
  int n_vec = 0, n_err = 0, cyc = 0;
  int ar_seen = 0, beats_seen = 0, rlast_cyc = 0, last_gap = 0;
  logic arv_prev = 1'b0;
  int err_beat = -1, stall_left = 0, dc_more = 0;
  int s_idx = 0, s_seq = 0, s_cur = 0;
  logic s_busy = 1'b0, s_ar_hs, s_r_hs, s_arv, ic_hs, dc_hs;
  logic [7:0] s_len = 8'h0, s_len_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_ar(input logic own, input logic [31:0] addr, input logic [7:0] len);
    ar_t e;
    e.own = own; e.addr = addr; e.len = len;
    ar_q.push_back(e);
  endtask

  task automatic req_ic(input logic [31:0] addr, input logic [7:0] len);
    ic_araddr = addr; ic_arlen = len; ic_arvalid = 1'b1;
  endtask

  task automatic req_dc(input logic [31:0] addr, input logic [7:0] len);
    dc_araddr = addr; dc_arlen = len; dc_arvalid = 1'b1;
  endtask

  task automatic wait_rise(input string tag);
    logic found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge aclk);
      if (m_arvalid) begin found = 1'b1; break; end
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    logic done = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge aclk); #1;
      if (ar_q.size() == 0 && beat_q.size() == 0 && !m_arvalid && !m_rready &&
          !ic_arvalid && !dc_arvalid) begin done = 1'b1; break; end
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  always @(posedge aclk) cyc <= cyc + 1;

  // AXI slave: optional AR stall, then one beat per cycle; shares the reset.
  always @(posedge aclk) begin
    s_ar_hs  = m_arvalid && m_arready;
    s_r_hs   = m_rvalid && m_rready;
    s_arv    = m_arvalid;
    s_len_in = m_arlen;
    #1;
    if (!aresetn) begin
      s_busy = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_arready = 1'b0;
    end else begin
      if (s_r_hs) begin
        if (m_rlast) s_busy = 1'b0;
        else s_idx++;
      end
      if (s_ar_hs) begin
        s_busy = 1'b1; s_len = s_len_in; s_idx = 0; s_cur = s_seq; s_seq++;
      end
      if (!s_busy && s_arv && !s_ar_hs && stall_left > 0) stall_left--;
      m_arready = !s_busy && (stall_left == 0);
      m_rvalid  = s_busy;
      m_rlast   = s_busy && (s_idx == 32'(s_len));
      m_rdata   = 32'(32'h11 * (s_idx + 1) + (s_cur << 16));
      m_rresp   = (s_idx == err_beat) ? 2'b10 : 2'b00;
    end
  end

  // Requesters drop arvalid after their handshake; DC may re-request back to back.
  always @(posedge aclk) begin
    ic_hs = ic_arvalid && ic_arready;
    dc_hs = dc_arvalid && dc_arready;
    #1;
    if (ic_hs) ic_arvalid = 1'b0;
    if (dc_hs) begin
      if (dc_more > 0) begin dc_more--; dc_araddr = dc_araddr + 32'h40; end
      else dc_arvalid = 1'b0;
    end
  end

  // Scoreboard: AR issues and R beats checked against queued expectations.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (m_arvalid && !arv_prev) last_gap = cyc - rlast_cyc;
      if (m_arvalid && m_arready) begin
        chk("ar_expected", 32'(ar_q.size() > 0), 32'd1);
        if (ar_q.size() > 0) begin
          ar_t e;
          e = ar_q.pop_front();
          chk("ar_id", 32'(m_arid), e.own ? 32'd1 : 32'd0);
          chk("ar_addr", m_araddr, e.addr);
          chk("ar_len", 32'(m_arlen), 32'(e.len));
          chk("ar_size", 32'(m_arsize), 32'd2);
          chk("ar_burst", 32'(m_arburst), 32'd1);
          for (int i = 0; i <= 32'(e.len); i++) begin
            beat_t b;
            b.own  = e.own;
            b.data = 32'(32'h11 * (i + 1) + (ar_seen << 16));
            b.resp = (i == err_beat) ? 2'b10 : 2'b00;
            b.last = (i == 32'(e.len));
            beat_q.push_back(b);
          end
          ar_seen++;
        end
      end
      if (m_rvalid && m_rready) begin
        chk("r_expected", 32'(beat_q.size() > 0), 32'd1);
        if (beat_q.size() > 0) begin
          beat_t b;
          b = beat_q.pop_front();
          chk("r_owner_valid", 32'(b.own ? dc_rvalid : ic_rvalid), 32'd1);
          chk("r_other_valid", 32'(b.own ? ic_rvalid : dc_rvalid), 32'd0);
          chk("r_data", b.own ? dc_rdata : ic_rdata, b.data);
          chk("r_resp", 32'(b.own ? dc_rresp : ic_rresp), 32'(b.resp));
          chk("r_last", 32'(b.own ? dc_rlast : ic_rlast), 32'(b.last));
        end
        beats_seen++;
        if (m_rlast) rlast_cyc = cyc;
      end else begin
        chk("r_quiet", 32'({ic_rvalid, dc_rvalid}), 32'd0);
      end
    end
    arv_prev = m_arvalid;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int k0, b0, low;
    repeat (3) @(negedge aclk);
    chk("rst_arvalid", 32'(m_arvalid), 32'd0);
    chk("rst_rready", 32'(m_rready), 32'd0);
    chk("rst_arready", 32'({ic_arready, dc_arready}), 32'd0);
    chk("rst_rvalid", 32'({ic_rvalid, dc_rvalid}), 32'd0);
    chk("rst_starve", 32'(dut.starve), 32'd0);
    aresetn = 1'b1;

    // IC only, 4-beat burst, one-cycle request-to-AR latency
    @(negedge aclk);
    push_ar(1'b0, 32'hBFC0_0000, 8'd3);
    req_ic(32'hBFC0_0000, 8'd3);
    k0 = cyc;
    wait_rise("t1_ar_timeout");
    chk("t1_latency", 32'(cyc - k0), 32'd1);
    wait_idle("t1_idle");
    chk("t1_beats", 32'(beats_seen), 32'd4);

    // simultaneous requests: DC first, IC after one IDLE cycle
    @(negedge aclk);
    push_ar(1'b1, 32'h8000_1000, 8'd1);
    push_ar(1'b0, 32'h0000_2000, 8'd0);
    req_dc(32'h8000_1000, 8'd1);
    req_ic(32'h0000_2000, 8'd0);
    wait_idle("t2_idle");
    chk("t2_gap", 32'(last_gap), 32'd2);

    // starvation: DC x4, IC, DC
    @(negedge aclk);
    for (int i = 0; i < 4; i++) push_ar(1'b1, 32'h4000_0000 + 32'(i * 32'h40), 8'd0);
    push_ar(1'b0, 32'h0000_3000, 8'd0);
    push_ar(1'b1, 32'h4000_0100, 8'd0);
    dc_more = 4;
    req_dc(32'h4000_0000, 8'd0);
    req_ic(32'h0000_3000, 8'd0);
    wait_idle("t3_idle");
    chk("t3_starve_clear", 32'(dut.starve), 32'd0);

    // AR stall of 5 cycles
    @(negedge aclk);
    stall_left = 5;
    push_ar(1'b0, 32'h1000_0000, 8'd1);
    req_ic(32'h1000_0000, 8'd1);
    wait_rise("t4_ar_timeout");
    low = 0;
    for (int k = 0; k < 20; k++) begin
      if (ic_arready) break;
      chk("t4_arvalid_hold", 32'(m_arvalid), 32'd1);
      chk("t4_addr_hold", m_araddr, 32'h1000_0000);
      low++;
      @(negedge aclk);
    end
    chk("t4_stall_cycles", 32'(low), 32'd5);
    @(negedge aclk);
    chk("t4_arready_pulse", 32'(ic_arready), 32'd0);
    wait_idle("t4_idle");

    // error response on beat 2 of a DC burst
    @(negedge aclk);
    err_beat = 1;
    b0 = beats_seen;
    push_ar(1'b1, 32'h2000_0000, 8'd3);
    req_dc(32'h2000_0000, 8'd3);
    wait_idle("t5_idle");
    err_beat = -1;
    chk("t5_beats", 32'(beats_seen - b0), 32'd4);
    chk("t5_state", 32'(dut.state), 32'd0);

    // reset in the middle of a burst
    @(negedge aclk);
    b0 = beats_seen;
    push_ar(1'b0, 32'h3000_0000, 8'd3);
    req_ic(32'h3000_0000, 8'd3);
    for (int k = 0; k < 50; k++) begin
      @(negedge aclk); #1;
      if (beats_seen >= b0 + 2) break;
    end
    chk("t6_two_beats", 32'(beats_seen - b0), 32'd2);
    @(posedge aclk); #2;
    aresetn = 1'b0;
    @(posedge aclk); #1;
    beat_q.delete();
    @(negedge aclk);
    chk("t6_state", 32'(dut.state), 32'd0);
    chk("t6_arvalid", 32'(m_arvalid), 32'd0);
    chk("t6_rready", 32'(m_rready), 32'd0);
    chk("t6_arready", 32'({ic_arready, dc_arready}), 32'd0);
    chk("t6_rvalid", 32'({ic_rvalid, dc_rvalid}), 32'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    b0 = beats_seen;
    push_ar(1'b0, 32'h3000_1000, 8'd1);
    req_ic(32'h3000_1000, 8'd1);
    wait_idle("t6_idle");
    chk("t6_new_beats", 32'(beats_seen - b0), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the core's single AXI4 read-address/read-data channel pair between the instruction-fetch requester (ic_*) and the data-load requester (dc_*).
- Sits between the fetch and load/store units and the AXI master ports of the CPU top.
- Keeps one read transaction outstanding at a time and routes returning beats to the requester that owns it.
- Write channels do not pass through this block.

Parameters:
- STARVE_LIMIT, 4: consecutive DC grants allowed while IC is pending before IC is forced to win.
- IC_ID, 4'd0: ARID driven for IC transactions.
- DC_ID, 4'd1: ARID driven for DC transactions.

Ports:
aclk  in  1  clock
aresetn  in  1  reset; one clock, reset is synchronous and active-low
ic_arvalid  in  1  IC read request valid
ic_arready  out  1  IC request accepted
ic_araddr  in  32  IC byte address
ic_arlen  in  8  IC burst length minus 1
ic_rvalid  out  1  IC data beat valid
ic_rdata  out  32  IC beat data
ic_rlast  out  1  IC final beat
ic_rresp  out  2  IC beat response
dc_arvalid  in  1  DC read request valid
dc_arready  out  1  DC request accepted
dc_araddr  in  32  DC byte address
dc_arlen  in  8  DC burst length minus 1
dc_rvalid  out  1  DC data beat valid
dc_rdata  out  32  DC beat data
dc_rlast  out  1  DC final beat
dc_rresp  out  2  DC beat response
m_arvalid  out  1  AXI AR valid
m_arready  in  1  AXI AR ready
m_araddr  out  32  AXI AR address
m_arlen  out  8  AXI AR length
m_arsize  out  3  constant 3'b010
m_arburst  out  2  constant 2'b01 (INCR)
m_arid  out  4  IC_ID or DC_ID of the owner
m_rvalid  in  1  AXI R valid
m_rready  out  1  AXI R ready
m_rdata  in  32  AXI R data
m_rlast  in  1  AXI R last
m_rresp  in  2  AXI R response

Behaviour:
- FSM states: IDLE, ADDR, DATA. Registered owner bit `own` (0 = IC, 1 = DC) and a starvation counter `starve` (width clog2(STARVE_LIMIT+1)).
- Reset (aresetn = 0 at a rising edge):
  - state = IDLE, own = 0, starve = 0.
  - m_arvalid, m_rready, ic/dc_arready and ic/dc_rvalid all 0.
  - A reset mid-burst abandons the transaction; the AXI slave shares this reset.
- IDLE, sampled each cycle:
  - Neither requester valid: stay in IDLE.
  - Only one valid: grant it.
  - Both valid: grant DC unless starve == STARVE_LIMIT, in which case grant IC.
  - On a grant: load own, go to ADDR next cycle.
  - starve increments on a DC grant while ic_arvalid = 1, saturating at STARVE_LIMIT. It clears on any IC grant.
- ADDR:
  - m_arvalid = 1. m_araddr and m_arlen are muxed combinationally from the owner. m_arid is IC_ID or DC_ID per own.
  - Owner's arready = m_arready; the other requester's arready = 0.
  - On m_arvalid && m_arready: go to DATA.
  - Requesters must hold arvalid, addr and len stable until their arready, per AXI. A requester that deasserts arvalid in IDLE before being granted is simply not granted.
- DATA:
  - m_rready = 1. Requesters have no backpressure and must sink a beat every cycle.
  - Owner's rvalid = m_rvalid; the other requester's rvalid = 0.
  - rdata, rresp and rlast go to both requesters; only the owner's is qualified by rvalid.
  - On m_rvalid && m_rlast: go to IDLE.
  - An error rresp is forwarded unchanged and does not shorten the burst.
- m_rready = 0 outside DATA, so stray R beats are never accepted in IDLE or ADDR.
- Latency:
  - Request seen in IDLE at cycle N gives m_arvalid at N+1.
  - Minimum gap between transactions is one IDLE cycle, after the rlast beat.
- Only one transaction is outstanding at a time. RID is not checked.

Test Plan:
- IC only, ic_araddr = 0xBFC00000, arlen = 3, m_arready high:
  - m_arvalid at cycle 1 with arid 0 and arsize 2.
  - Four beats 0x11..0x44 appear only on ic_rvalid, ic_rlast on the 4th.
  - dc_rvalid stays 0 throughout.
- IC and DC both valid in the same cycle:
  - DC is granted first (arid 1).
  - After DC's rlast, one IDLE cycle, then the IC AR is issued.
- STARVE_LIMIT = 4, IC held valid, DC re-requests continuously:
  - Grants are DC×4, then IC, then DC.
  - starve returns to 0 after the IC grant.
- m_arready held low for 5 cycles in ADDR:
  - m_arvalid and m_araddr stay stable; owner's arready is 0 until cycle 6, then pulses for 1 cycle.
- m_rresp = 2'b10 on beat 2 of a 4-beat DC burst:
  - dc_rresp = 2'b10 on that beat, all 4 beats delivered, FSM returns to IDLE after rlast.
- aresetn low at beat 2 of a burst:
  - Next cycle state is IDLE and all valids/readys are 0.
  - A new IC request afterwards issues normally.
